// File: rtl/shftreg_pkg.sv
// Shared definitions for the universal shift register family.
//   mode_e  : shift/rotate mode encodings driven on MODE
//   state_e : burst engine FSM states
package shftreg_pkg;

  typedef enum logic [1:0] {
    MODE_SR = 2'b00,  // logical shift right, InS enters at MSB
    MODE_SL = 2'b01,  // logical shift left, InS enters at LSB
    MODE_RR = 2'b10,  // rotate right
    MODE_RL = 2'b11   // rotate left
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/shftreg_step.sv
// Combinational one-step next-value logic for the universal shift register.
// Shared by the single-step (SHFT) and burst paths.
// Ports:
//   mode_i  shift/rotate mode
//   d_i     current register contents
//   ins_i   serial input for logical shifts
//   d_o     register contents after one step
//   out_o   bit shifted or rotated out by this step
module shftreg_step
  import shftreg_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  mode_e            mode_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             ins_i,
  output logic [WIDTH-1:0] d_o,
  output logic             out_o
);

  always_comb begin
    d_o   = d_i;
    out_o = 1'b0;
    unique case (mode_i)
      MODE_SR: begin
        d_o   = {ins_i, d_i[WIDTH-1:1]};
        out_o = d_i[0];
      end
      MODE_SL: begin
        d_o   = {d_i[WIDTH-2:0], ins_i};
        out_o = d_i[WIDTH-1];
      end
      MODE_RR: begin
        d_o   = {d_i[0], d_i[WIDTH-1:1]};
        out_o = d_i[0];
      end
      MODE_RL: begin
        d_o   = {d_i[WIDTH-2:0], d_i[WIDTH-1]};
        out_o = d_i[WIDTH-1];
      end
      default: begin
        d_o   = d_i;
        out_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shftreg_univ.sv
// Universal shift register: parallel load, synchronous clear, single-step
// shift/rotate, and a burst engine performing NSHIFT steps per START.
// All state updates on the falling edge of CLK; RST is asynchronous.
// Ports:
//   CLK    clock (falling-edge active)     RST    async reset, active high
//   CLR    sync clear                      LD     parallel load of InP
//   InP    parallel data                   InS    serial input
//   MODE   00 SR, 01 SL, 10 RR, 11 RL      SHFT   single step in IDLE
//   START  begin burst                     NSHIFT burst length
//   D      register contents               SOUT   last bit shifted out
//   BUSY   burst in progress               DONE   one-cycle completion pulse
module shftreg_univ
  import shftreg_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNTW  = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  input  logic             LD,
  input  logic [WIDTH-1:0] InP,
  input  logic             InS,
  input  logic [1:0]       MODE,
  input  logic             SHFT,
  input  logic             START,
  input  logic [CNTW-1:0]  NSHIFT,
  output logic [WIDTH-1:0] D,
  output logic             SOUT,
  output logic             BUSY,
  output logic             DONE
);

  state_e            state_q;
  mode_e             mode_q;
  logic [CNTW-1:0]   cnt_q;
  logic [WIDTH-1:0]  d_q;
  logic              sout_q;
  logic              busy_q;
  logic              done_q;

  mode_e             step_mode;
  logic [WIDTH-1:0]  step_d;
  logic              step_sout;

  // During a burst the latched mode drives the step; otherwise live MODE.
  assign step_mode = (state_q == ST_RUN) ? mode_q : mode_e'(MODE);

  shftreg_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .mode_i (step_mode),
    .d_i    (d_q),
    .ins_i  (InS),
    .d_o    (step_d),
    .out_o  (step_sout)
  );

  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_SR;
      cnt_q   <= '0;
      d_q     <= '0;
      sout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (CLR) begin
        state_q <= ST_IDLE;
        d_q     <= '0;
        sout_q  <= 1'b0;
        busy_q  <= 1'b0;
      end else if (LD) begin
        state_q <= ST_IDLE;
        d_q     <= InP;
        busy_q  <= 1'b0;
      end else if (state_q == ST_RUN) begin
        d_q    <= step_d;
        sout_q <= step_sout;
        cnt_q  <= cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
      end else if (START) begin
        // Zero-length burst completes immediately without entering RUN.
        if (NSHIFT != '0) begin
          state_q <= ST_RUN;
          mode_q  <= mode_e'(MODE);
          cnt_q   <= NSHIFT;
          busy_q  <= 1'b1;
        end else begin
          done_q <= 1'b1;
        end
      end else if (SHFT) begin
        d_q    <= step_d;
        sout_q <= step_sout;
      end
    end
  end

  assign D    = d_q;
  assign SOUT = sout_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_shftreg_univ.sv
module tb_shftreg_univ;

  localparam int unsigned W = 8;
  localparam int unsigned C = 4;

  logic         CLK = 1'b1;
  logic         RST = 1'b1;
  logic         CLR = 1'b0;
  logic         LD = 1'b0;
  logic [W-1:0] InP = '0;
  logic         InS = 1'b0;
  logic [1:0]   MODE = 2'b00;
  logic         SHFT = 1'b0;
  logic         START = 1'b0;
  logic [C-1:0] NSHIFT = '0;
  logic [W-1:0] D;
  logic         SOUT, BUSY, DONE;

  shftreg_univ #(.WIDTH(W), .CNTW(C)) dut (
    .CLK(CLK), .RST(RST), .CLR(CLR), .LD(LD), .InP(InP), .InS(InS),
    .MODE(MODE), .SHFT(SHFT), .START(START), .NSHIFT(NSHIFT),
    .D(D), .SOUT(SOUT), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] d;
    logic         sout;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t sb[$];

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // reference model state
  logic [W-1:0] m_d;
  logic         m_sout, m_busy, m_done, m_run;
  logic [1:0]   m_mode;
  logic [C-1:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_d = '0; m_sout = 1'b0; m_busy = 1'b0; m_done = 1'b0;
    m_run = 1'b0; m_mode = 2'b00; m_cnt = '0;
  endtask

  task automatic model_step(input logic [1:0] md);
    logic [W-1:0] o;
    o = m_d;
    case (md)
      2'b00: begin m_sout = o[0];   m_d = (o >> 1) | ({{(W-1){1'b0}}, InS} << (W-1)); end
      2'b01: begin m_sout = o[W-1]; m_d = (o << 1) | {{(W-1){1'b0}}, InS}; end
      2'b10: begin m_sout = o[0];   m_d = (o >> 1) | ({{(W-1){1'b0}}, o[0]} << (W-1)); end
      default: begin m_sout = o[W-1]; m_d = (o << 1) | {{(W-1){1'b0}}, o[W-1]}; end
    endcase
  endtask

  // Called at a rising edge with inputs already driven: predict the result of
  // the next falling edge, push it, then compare at the following rising edge.
  task automatic cyc(input string tag);
    exp_t e;
    m_done = 1'b0;
    if (CLR) begin
      m_d = '0; m_sout = 1'b0; m_run = 1'b0; m_busy = 1'b0;
    end else if (LD) begin
      m_d = InP; m_run = 1'b0; m_busy = 1'b0;
    end else if (m_run) begin
      model_step(m_mode);
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin m_run = 1'b0; m_busy = 1'b0; m_done = 1'b1; end
    end else if (START) begin
      if (NSHIFT != 0) begin
        m_run = 1'b1; m_busy = 1'b1; m_mode = MODE; m_cnt = NSHIFT;
      end else m_done = 1'b1;
    end else if (SHFT) begin
      model_step(MODE);
    end
    e.d = m_d; e.sout = m_sout; e.busy = m_busy; e.done = m_done;
    sb.push_back(e);
    @(posedge CLK);
    e = sb.pop_front();
    chk({tag, ".D"},    32'(D),    32'(e.d));
    chk({tag, ".SOUT"}, 32'(SOUT), 32'(e.sout));
    chk({tag, ".BUSY"}, 32'(BUSY), 32'(e.busy));
    chk({tag, ".DONE"}, 32'(DONE), 32'(e.done));
  endtask

  task automatic idle_inputs();
    CLR = 1'b0; LD = 1'b0; SHFT = 1'b0; START = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #2;
    chk("rst.D", 32'(D), 32'h0);
    chk("rst.SOUT", 32'(SOUT), 32'h0);
    chk("rst.BUSY", 32'(BUSY), 32'h0);
    chk("rst.DONE", 32'(DONE), 32'h0);
    @(posedge CLK);
    RST = 1'b0;

    // load then single shift right with InS=1
    LD = 1'b1; InP = 8'hA5; cyc("ldA5");
    idle_inputs(); SHFT = 1'b1; MODE = 2'b00; InS = 1'b1; cyc("shft_sr");
    chk("shft_sr.D_abs", 32'(D), 32'hD2);
    chk("shft_sr.SOUT_abs", 32'(SOUT), 32'h1);

    // rotate-left burst of 3 from 8'h81
    idle_inputs(); LD = 1'b1; InP = 8'h81; cyc("ld81");
    idle_inputs(); START = 1'b1; NSHIFT = 4'd3; MODE = 2'b11; cyc("rl3.e0");
    chk("rl3.busy_e0", 32'(BUSY), 32'h1);
    idle_inputs();
    cyc("rl3.e1"); cyc("rl3.e2"); cyc("rl3.e3");
    chk("rl3.D_abs", 32'(D), 32'h0C);
    chk("rl3.DONE_abs", 32'(DONE), 32'h1);
    chk("rl3.BUSY_abs", 32'(BUSY), 32'h0);
    chk("rl3.SOUT_abs", 32'(SOUT), 32'h0);
    cyc("rl3.after");
    chk("rl3.DONE_drop", 32'(DONE), 32'h0);

    // zero-length burst
    START = 1'b1; NSHIFT = 4'd0; cyc("n0");
    chk("n0.DONE_abs", 32'(DONE), 32'h1);
    chk("n0.D_abs", 32'(D), 32'h0C);
    idle_inputs(); cyc("n0.after");

    // burst aborted by LD at edge 2; MODE change mid-burst ignored
    START = 1'b1; NSHIFT = 4'd5; MODE = 2'b00; InS = 1'b0; cyc("ab.e0");
    idle_inputs(); MODE = 2'b11; cyc("ab.e1");
    chk("ab.D_e1", 32'(D), 32'h06);
    LD = 1'b1; InP = 8'h3C; cyc("ab.e2");
    chk("ab.D_abs", 32'(D), 32'h3C);
    chk("ab.BUSY_abs", 32'(BUSY), 32'h0);
    idle_inputs(); cyc("ab.e3"); cyc("ab.e4");
    chk("ab.noDONE", 32'(DONE), 32'h0);

    // CLR beats LD and SHFT
    LD = 1'b1; InP = 8'hFF; cyc("ldFF");
    CLR = 1'b1; LD = 1'b1; SHFT = 1'b1; InP = 8'h55; cyc("clr_pri");
    chk("clr_pri.D_abs", 32'(D), 32'h0);
    idle_inputs();

    // back-to-back bursts with START held; NSHIFT > WIDTH wraps
    LD = 1'b1; InP = 8'h96; cyc("ld96");
    idle_inputs(); START = 1'b1; NSHIFT = 4'd2; MODE = 2'b10;
    for (int i = 0; i < 8; i++) cyc("b2b");
    NSHIFT = 4'd11; MODE = 2'b01; InS = 1'b1;
    for (int i = 0; i < 13; i++) cyc("long");
    idle_inputs();

    // randomised traffic
    for (int i = 0; i < 300; i++) begin
      CLR    = ($urandom_range(31) == 0);
      LD     = ($urandom_range(15) == 0);
      InP    = W'($urandom);
      InS    = 1'($urandom);
      MODE   = 2'($urandom);
      SHFT   = 1'($urandom);
      START  = ($urandom_range(3) == 0);
      NSHIFT = ($urandom_range(4) == 0) ? '0 : C'($urandom_range(15));
      cyc("rnd");
    end

    // async reset mid-burst, between edges
    idle_inputs(); START = 1'b1; NSHIFT = 4'd7; MODE = 2'b11; cyc("ar.e0");
    idle_inputs(); cyc("ar.e1"); cyc("ar.e2");
    RST = 1'b1;
    #1;
    chk("ar.D", 32'(D), 32'h0);
    chk("ar.SOUT", 32'(SOUT), 32'h0);
    chk("ar.BUSY", 32'(BUSY), 32'h0);
    chk("ar.DONE", 32'(DONE), 32'h0);
    model_reset();
    #2;
    RST = 1'b0;
    LD = 1'b1; InP = 8'h5A; cyc("ar.ld");
    idle_inputs(); START = 1'b1; NSHIFT = 4'd1; MODE = 2'b01; InS = 1'b0; cyc("ar.s0");
    idle_inputs(); cyc("ar.s1"); cyc("ar.s2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
